// File: rtl/mem_alu_exec.sv
// mem_alu_exec: single-accumulator execution unit with a request/acknowledge
// memory port. One instruction runs per start: the operand address goes into
// MAR, memory is read into MBR or written from AC, and the ALU updates AC and
// the carry/zero flags. A stalled memory access is abandoned after TIMEOUT
// wait cycles.
//
// Memory handshake: mem_req is high for the whole time the unit sits in READ
// or WRITE. A transfer completes on the rising edge where mem_req and mem_ack
// are both high. mem_we, mem_addr and mem_wdata are stable while mem_req is
// high. mem_rdata is sampled on that same edge. mem_ack is ignored while
// mem_req is low.
module mem_alu_exec #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 14,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] acc,
    output logic              carry,
    output logic              zero,
    output logic [ADDR_W-1:0] mar,
    output logic [DATA_W-1:0] mbr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [2:0]        dbg_state
);

    // Opcode encoding
    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_STORE = 3'b001;
    localparam logic [2:0] OP_ADD   = 3'b010;
    localparam logic [2:0] OP_SUB   = 3'b011;
    localparam logic [2:0] OP_AND   = 3'b100;
    localparam logic [2:0] OP_OR    = 3'b101;
    localparam logic [2:0] OP_XOR   = 3'b110;
    localparam logic [2:0] OP_CLEAR = 3'b111;

    // The wait counter must be able to hold TIMEOUT itself
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    // The count about to reach TIMEOUT: with no ack in this cycle we abort
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LDMAR = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_EXEC  = 3'd4,
        S_DONE  = 3'd5,
        S_ABORT = 3'd6
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        op_r;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timed_out;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;

    // The memory port mirrors the address and accumulator registers
    assign mem_addr  = mar;
    assign mem_wdata = acc;
    assign dbg_state = state;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs. Every output here is a pure
    // function of the state, so the asynchronous reset also clears them at once.
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
        err       = (state == S_ABORT);
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        timed_out = (wait_cnt == CNT_LAST);
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_LDMAR;
                end
            end
            S_LDMAR: begin
                case (op_r)
                    OP_CLEAR: state_nxt = S_EXEC;
                    OP_STORE: state_nxt = S_WRITE;
                    default:  state_nxt = S_READ;
                endcase
            end
            S_READ: begin
                mem_req = 1'b1;
                // An ack in the last allowed cycle still completes the read
                if (mem_ack) begin
                    state_nxt = S_EXEC;
                end else if (timed_out) begin
                    state_nxt = S_ABORT;
                end
            end
            S_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    state_nxt = S_DONE;
                end else if (timed_out) begin
                    state_nxt = S_ABORT;
                end
            end
            S_EXEC:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            S_ABORT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ALU: result and carry/borrow for the latched opcode, applied in EXEC
    always_comb begin
        alu_res   = acc;
        alu_carry = 1'b0;
        case (op_r)
            OP_LOAD:  alu_res = mbr;
            OP_ADD:   {alu_carry, alu_res} = {1'b0, acc} + {1'b0, mbr};
            OP_SUB: begin
                alu_res   = acc - mbr;
                alu_carry = (acc < mbr);
            end
            OP_AND:   alu_res = acc & mbr;
            OP_OR:    alu_res = acc | mbr;
            OP_XOR:   alu_res = acc ^ mbr;
            OP_CLEAR: alu_res = '0;
            default: begin
                // STORE never reaches EXEC; keep the flags as they are
                alu_res   = acc;
                alu_carry = carry;
            end
        endcase
    end

    // Datapath registers: opcode/MAR capture, MBR load and accumulator update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r  <= OP_LOAD;
            mar   <= '0;
            mbr   <= '0;
            acc   <= '0;
            carry <= 1'b0;
            zero  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r <= op;
                        mar  <= addr;
                    end
                end
                S_READ: begin
                    if (mem_ack) begin
                        mbr <= mem_rdata;
                    end
                end
                S_EXEC: begin
                    acc   <= alu_res;
                    carry <= alu_carry;
                    zero  <= (alu_res == '0);
                end
                default: begin
                end
            endcase
        end
    end

    // Wait counter: counts unacknowledged request cycles and is zero on entry
    // to READ or WRITE because every other state holds it at zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if ((state == S_READ || state == S_WRITE) && !mem_ack) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end else begin
            wait_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_mem_alu_exec.sv
// tb_mem_alu_exec: randomized and directed stimulus for mem_alu_exec with a
// behavioural accumulator model, a memory responder with programmable ack
// delay, and a monitor that checks every done/err pulse against the queue of
// predicted results.
module tb_mem_alu_exec;

    localparam int DW  = 16;
    localparam int AW  = 14;
    localparam int TMO = 4;
    localparam int EW  = 1 + DW + 1 + 1 + DW;

    // Clock and reset
    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0;
    logic [2:0]    op    = 3'd0;
    logic [AW-1:0] addr  = '0;
    logic          busy, done, err, carry, zero, mem_req, mem_we;
    logic [DW-1:0] acc, mbr, mem_wdata;
    logic [AW-1:0] mar, mem_addr;
    logic [2:0]    dbg_state;
    logic          mem_ack   = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    mem_alu_exec #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .acc       (acc),
        .carry     (carry),
        .zero      (zero),
        .mar       (mar),
        .mbr       (mbr),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // Scoreboard queues: {is_err, acc, carry, zero, mbr} per instruction,
    // {addr, data} per expected memory write
    logic [EW-1:0]    exp_q[$];
    logic [AW+DW-1:0] wr_q[$];

    // Memory seen by the responder and the model's own copy
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    // Reference architectural state
    logic [DW-1:0] m_acc   = '0;
    logic [DW-1:0] m_mbr   = '0;
    logic          m_carry = 1'b0;
    logic          m_zero  = 1'b0;

    int ack_delay  = 0;
    int req_cyc    = 0;
    int req_hi_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic report;
        $display("test done: total=%0d bad=%0d", total, bad);
    endtask

    // Memory responder: acks after ack_delay request cycles, serves reads and
    // checks each write against the predicted write stream
    always @(negedge clk) begin
        if (!reset || !mem_req) begin
            mem_ack = 1'b0;
            req_cyc = 0;
        end else begin
            req_hi_cnt++;
            if (req_cyc == ack_delay) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    if (wr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_write: addr %h data %h", mem_addr, mem_wdata);
                    end else begin
                        logic [AW+DW-1:0] w;
                        w = wr_q.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(w[AW+DW-1:DW]));
                        check("wr_data", 32'(mem_wdata), 32'(w[DW-1:0]));
                    end
                    mem[mem_addr] = mem_wdata;
                end else begin
                    mem_rdata = mem[mem_addr];
                end
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = DW'($urandom);
            end
            req_cyc++;
        end
    end

    // Monitor: every done/err pulse consumes one predicted result
    always @(negedge clk) begin
        if (reset && (done || err)) begin
            check("done_err_excl", 32'(done & err), 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pulse: done=%0b err=%0b with nothing expected", done, err);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("res_err",   32'(err),   32'(e[EW-1]));
                check("res_done",  32'(done),  32'(!e[EW-1]));
                check("res_acc",   32'(acc),   32'(e[2*DW+1:DW+2]));
                check("res_carry", 32'(carry), 32'(e[DW+1]));
                check("res_zero",  32'(zero),  32'(e[DW]));
                check("res_mbr",   32'(mbr),   32'(e[DW-1:0]));
            end
        end
    end

    // Reference model: applies one instruction with plain integer arithmetic
    // and predicts its outcome, latency and number of request cycles
    task automatic model_op(input logic [2:0] o, input logic [AW-1:0] a, input int d,
                            output int exp_lat, output int exp_req);
        bit ok;
        int x, y, r;
        ok = (o == 3'd7) || (d < TMO);
        if (o == 3'd7) begin
            exp_lat = 3;
            exp_req = 0;
        end else if (!ok) begin
            exp_lat = 2 + TMO;
            exp_req = TMO;
        end else begin
            exp_lat = (o == 3'd1) ? 3 + d : 4 + d;
            exp_req = d + 1;
        end
        if (ok) begin
            if (o != 3'd1 && o != 3'd7) m_mbr = ref_mem[a];
            x = int'(m_acc);
            y = int'(m_mbr);
            r = x;
            case (o)
                3'd0: begin r = y; m_carry = 1'b0; end
                3'd1: begin
                    ref_mem[a] = m_acc;
                    wr_q.push_back({a, m_acc});
                end
                3'd2: begin r = x + y; m_carry = (r > 65535); r = r % 65536; end
                3'd3: begin m_carry = (x < y); r = x - y; if (r < 0) r = r + 65536; end
                3'd4: begin r = x & y; m_carry = 1'b0; end
                3'd5: begin r = x | y; m_carry = 1'b0; end
                3'd6: begin r = x ^ y; m_carry = 1'b0; end
                default: begin r = 0; m_carry = 1'b0; end
            endcase
            if (o != 3'd1) begin
                m_acc  = DW'(r);
                m_zero = (r == 0);
            end
        end
        exp_q.push_back({!ok, m_acc, m_carry, m_zero, m_mbr});
    endtask

    // Driver: issues one instruction from a negedge, optionally pokes start
    // while busy, and checks latency, request length and busy afterwards
    task automatic do_op(input logic [2:0] o, input logic [AW-1:0] a, input int d, input bit poke);
        int exp_lat, exp_req, lat;
        bit seen;
        ack_delay  = d;
        req_hi_cnt = 0;
        model_op(o, a, d, exp_lat, exp_req);
        start = 1'b1;
        op    = o;
        addr  = a;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        seen = 1'b0;
        while (!seen && lat < 60) begin
            if (done || err) begin
                seen = 1'b1;
            end else begin
                start = poke && (lat == 2);
                op    = (poke && lat == 2) ? 3'd7 : 3'($urandom);
                addr  = AW'($urandom);
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL completion_timeout: op %0d no done/err within %0d cycles", o, lat);
        end else begin
            check("latency", 32'(lat), 32'(exp_lat));
            check("req_cycles", 32'(req_hi_cnt), 32'(exp_req));
            @(posedge clk);
            @(negedge clk);
            check("busy_after", 32'(busy), 32'd0);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_acc"},     32'(acc),     32'd0);
        check({tag, "_carry"},   32'(carry),   32'd0);
        check({tag, "_zero"},    32'(zero),    32'd0);
        check({tag, "_mar"},     32'(mar),     32'd0);
        check({tag, "_mbr"},     32'(mbr),     32'd0);
        check({tag, "_busy"},    32'(busy),    32'd0);
        check({tag, "_done"},    32'(done),    32'd0);
        check({tag, "_err"},     32'(err),     32'd0);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        report();
        $fatal(1, "watchdog");
    end

    // Main sequence
    initial begin
        logic [DW-1:0] v;
        for (int i = 0; i < (1 << AW); i++) begin
            v = DW'($urandom);
            mem[i]     = v;
            ref_mem[i] = v;
        end
        mem[5]  = 16'h0003; ref_mem[5]  = 16'h0003;
        mem[7]  = 16'h0001; ref_mem[7]  = 16'h0001;
        mem[8]  = 16'hFFFF; ref_mem[8]  = 16'hFFFF;
        mem[9]  = 16'h0005; ref_mem[9]  = 16'h0005;
        mem[10] = 16'h0002; ref_mem[10] = 16'h0002;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outs("por");
        reset = 1'b1;
        @(negedge clk);

        // Basic load/add sequence
        do_op(3'd7, 14'd0, 0, 1'b0);
        do_op(3'd0, 14'd5, 0, 1'b0);
        do_op(3'd2, 14'd5, 0, 1'b0);
        check("add_acc", 32'(acc), 32'h0006);
        check("add_carry", 32'(carry), 32'd0);
        check("add_zero", 32'(zero), 32'd0);

        // Add wrap to zero
        do_op(3'd0, 14'd8, 0, 1'b0);
        do_op(3'd2, 14'd7, 0, 1'b0);
        check("wrap_acc", 32'(acc), 32'h0000);
        check("wrap_carry", 32'(carry), 32'd1);
        check("wrap_zero", 32'(zero), 32'd1);

        // Subtract with borrow, then store to the top address
        do_op(3'd0, 14'd10, 0, 1'b0);
        do_op(3'd3, 14'd9, 0, 1'b0);
        check("sub_acc", 32'(acc), 32'hFFFD);
        check("sub_borrow", 32'(carry), 32'd1);
        do_op(3'd1, 14'h3FFF, 0, 1'b0);
        check("store_mem", 32'(mem[14'h3FFF]), 32'hFFFD);
        check("store_acc", 32'(acc), 32'hFFFD);
        check("store_carry", 32'(carry), 32'd1);
        check("store_zero", 32'(zero), 32'd0);

        // Timeouts and the ack-on-last-cycle boundary
        do_op(3'd0, 14'd5, 99, 1'b0);
        check("abort_acc", 32'(acc), 32'hFFFD);
        do_op(3'd0, 14'd7, TMO - 1, 1'b0);
        check("late_ack_acc", 32'(acc), 32'h0001);
        do_op(3'd1, 14'd20, TMO, 1'b0);
        do_op(3'd1, 14'd21, TMO - 1, 1'b0);

        // Start while busy is ignored
        do_op(3'd2, 14'd5, 3, 1'b1);

        // Random instruction mix
        for (int n = 0; n < 80; n++) begin
            logic [2:0]    ro;
            logic [AW-1:0] ra;
            int            rd;
            ro = 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            rd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TMO + 2) : 0;
            do_op(ro, ra, rd, ($urandom_range(0, 7) == 0) && (rd >= 2));
        end

        // Reset during a slow read, with start poked while busy
        ack_delay = 3;
        start = 1'b1; op = 3'd0; addr = 14'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = 3'd7;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("mid_busy", 32'(busy), 32'd1);
        check("mid_req", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1 check_reset_outs("mid_reset");
        m_acc = '0; m_mbr = '0; m_carry = 1'b0; m_zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_reset_outs("held_reset");
        #2 reset = 1'b1;
        @(negedge clk);

        // First start after reset is accepted straight away
        do_op(3'd0, 14'd9, 0, 1'b0);
        check("post_reset_acc", 32'(acc), 32'h0005);
        do_op(3'd6, 14'd7, 1, 1'b0);
        check("post_reset_xor", 32'(acc), 32'h0004);

        repeat (5) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        report();
        $finish;
    end

endmodule

// File: doc/mem_alu_exec.md
MEM_ALU_EXEC -- requirements
Module: mem_alu_exec

Interface
REQ-001 Parameter DATA_W, default 16: width of the accumulator, memory data, MBR and operand paths.
REQ-002 Parameter ADDR_W, default 14: memory address width, covering 16Ki words.
REQ-003 Parameter TIMEOUT, default 255: maximum wait cycles for mem_ack before abort; must be at least 1.
REQ-004 clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  request to execute one instruction; sampled only in IDLE.
REQ-007 op  in  3  opcode: 000 LOAD, 001 STORE, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 CLEAR.
REQ-008 addr  in  ADDR_W  operand address X.
REQ-009 busy  out  1  high in every state except IDLE.
REQ-010 done  out  1  one-cycle pulse on successful completion.
REQ-011 err  out  1  one-cycle pulse when an operation aborts on timeout.
REQ-012 acc  out  DATA_W  accumulator AC.
REQ-013 carry  out  1  carry flag for ADD; borrow flag for SUB.
REQ-014 zero  out  1  high when the last AC result is 0.
REQ-015 mar  out  ADDR_W  memory address register.
REQ-016 mbr  out  DATA_W  memory buffer register.
REQ-017 mem_req  out  1  memory request; held high until mem_ack.
REQ-018 mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
REQ-019 mem_addr  out  ADDR_W  driven from mar.
REQ-020 mem_wdata  out  DATA_W  driven from acc.
REQ-021 mem_rdata  in  DATA_W  read data; valid in the same cycle as mem_ack.
REQ-022 mem_ack  in  1  completes the outstanding request; ignored while mem_req is low.

Function
REQ-023 FSM states SHALL be IDLE, LDMAR, READ, WRITE, EXEC, DONE and ABORT.
REQ-024 In IDLE with start=1, the block SHALL latch op and load mar<=addr in the same edge, then go to LDMAR; start in any other state SHALL be ignored.
REQ-025 LDMAR SHALL go to READ for LOAD/ADD/SUB/AND/OR/XOR, to WRITE for STORE, and to EXEC for CLEAR (no memory access).
REQ-026 In READ, the block SHALL hold mem_req=1 and mem_we=0; on mem_ack it SHALL set mbr<=mem_rdata and go to EXEC.
REQ-027 In WRITE, the block SHALL hold mem_req=1, mem_we=1 and mem_wdata=acc; on mem_ack it SHALL go to DONE.
REQ-028 EXEC SHALL perform one update, then go to DONE:
- LOAD: acc<=mbr
- ADD: {carry,acc}<=acc+mbr, DATA_W+1 bits
- SUB: acc<=acc-mbr modulo 2^DATA_W; carry<=(acc<mbr) unsigned
- AND/OR/XOR: acc<=acc op mbr
- CLEAR: acc<=0
REQ-029 zero SHALL be updated from the new acc in EXEC. carry SHALL be cleared by LOAD/AND/OR/XOR/CLEAR. STORE SHALL leave acc, carry and zero unchanged.
REQ-030 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-031 A wait counter SHALL clear on entry to READ or WRITE and increment each cycle without mem_ack.
REQ-032 If the count reaches TIMEOUT without mem_ack, the block SHALL drop mem_req and go to ABORT; ABORT SHALL pulse err for one cycle and return to IDLE, with acc, carry, zero and mbr unchanged.
REQ-033 mem_ack arriving in the same cycle the count reaches TIMEOUT SHALL win: the operation completes and no abort occurs.
REQ-034 With a zero-wait memory (ack in the first request cycle), read-type ops SHALL take 4 edges from start to done=1, STORE 3, CLEAR 3.
REQ-035 done and err SHALL never be high in the same cycle; busy SHALL be low in the cycle after done or err.

Reset
REQ-036 While reset=0, the block SHALL asynchronously force state=IDLE; acc, mar, mbr, carry, zero, busy, done, err and mem_req to 0; and the wait counter to 0.
REQ-037 Reset asserted mid-operation SHALL abandon the operation with no done or err pulse; mem_req SHALL drop immediately.
REQ-038 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-039 Zero-wait memory with mem[5]=0x0003: CLEAR, then LOAD 5, then ADD 5 -> acc=0x0006, carry=0, zero=0; done 4 edges after each read-type start.
REQ-040 acc=0xFFFF, mem[7]=0x0001: ADD 7 -> acc=0x0000, carry=1, zero=1.
REQ-041 acc=0x0002, mem[9]=0x0005: SUB 9 -> acc=0xFFFD, carry=1; then STORE 0x3FFF -> write of 0xFFFD to 0x3FFF, flags unchanged.
REQ-042 TIMEOUT=4, mem_ack never asserted on LOAD -> mem_req high for 4 cycles, err pulses once, acc unchanged, no done.
REQ-043 mem_ack delayed 3 cycles, start pulsed while busy, then reset pulled low during READ -> the second start is ignored; after reset, all outputs are 0 and no done pulse occurs.
